// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronized, counter-qualified push-button debouncer
//
// Purpose:
//   Takes a raw mechanical button level that is asynchronous to i_clock and
//   may bounce. Produces a clean, registered level plus single-cycle edge
//   pulses. A new level is accepted only after the synchronized input has
//   disagreed with the current accepted level long enough for the qualify
//   counter to reach DEBOUNCE_CYCLES-1.
//
// Parameters:
//   DEBOUNCE_CYCLES  qualification length in synchronized samples (2 .. 2^20)
//
// Ports:
//   i_clock    in   system clock, all state changes on the rising edge
//   i_reset    in   asynchronous, active-high reset (deassertion is expected
//                   to be synchronized upstream by the reset tree)
//   i_btn_raw  in   raw button level, asynchronous, may bounce
//   o_btn      out  debounced level, registered
//   o_rise     out  one-cycle pulse in the first cycle o_btn reads 1
//   o_fall     out  one-cycle pulse in the first cycle o_btn reads 0

module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn_raw,
    output logic o_btn,
    output logic o_rise,
    output logic o_fall
);

    // Counter only ever needs to reach DEBOUNCE_CYCLES-1, so ceil(log2(N))
    // bits suffice. The guard keeps the width legal if someone sets N=1.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Encoding keeps bit 1 equal to the accepted level in the stable states
    // only by coincidence; o_btn is decoded explicitly below.
    localparam logic [1:0] ST_LOW       = 2'd0;
    localparam logic [1:0] ST_RISE_WAIT = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;
    localparam logic [1:0] ST_FALL_WAIT = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             btn_q,   btn_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    logic             cnt_done;

    assign cnt_done = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Synchronizer: only sync2 is ever looked at by the FSM.
        sync1_d = i_btn_raw;
        sync2_d = sync1_q;

        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_LOW: begin
                // Counter holds while stable; it is cleared on entry to a
                // wait state instead.
                if (sync2_q) begin
                    state_d = ST_RISE_WAIT;
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_RISE_WAIT: begin
                if (!sync2_q) begin
                    // Bounce: drop all progress, re-entry starts again at 0.
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_done) begin
                    state_d = ST_HIGH;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            ST_HIGH: begin
                if (!sync2_q) begin
                    state_d = ST_FALL_WAIT;
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_FALL_WAIT: begin
                if (sync2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_done) begin
                    state_d = ST_LOW;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_LOW;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Outputs are decoded from the next state so that the registered
        // level and its edge pulse appear in the same cycle.
        btn_d  = (state_d == ST_HIGH) || (state_d == ST_FALL_WAIT);
        rise_d = (state_q == ST_RISE_WAIT) && (state_d == ST_HIGH);
        fall_d = (state_q == ST_FALL_WAIT) && (state_d == ST_LOW);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_LOW;
            cnt_q   <= CNT_ZERO;
            btn_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_btn  = btn_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule
